// File: rtl/decode_stage.sv
// decode_stage: decodes fetched instructions into a two-entry (output + skid) buffer
// with registered in_ready, HLT intake stop, flush and a saturating handshake counter.
module decode_stage #(
    parameter int INSTR_W = 16,
    parameter int REG_AW  = 3,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_opcode,
    output logic [REG_AW-1:0]  out_rd,
    output logic [REG_AW-1:0]  out_rs1,
    output logic [REG_AW-1:0]  out_rs2,
    output logic               out_is_imm,
    output logic [DATA_W-1:0]  out_imm,
    output logic [INSTR_W-5:0] out_jump_target,
    output logic               out_writes_rd,
    output logic               out_is_branch,
    output logic               halted,
    output logic [CNT_W-1:0]   decode_count
);
    localparam int IMM_W = INSTR_W - 4 - 2 * REG_AW;
    // Per-opcode property tables, bit n describes opcode n.
    localparam logic [15:0] IMM_MASK = 16'b1101_1101_0110_1101;
    localparam logic [15:0] WR_MASK  = 16'b0101_1001_1001_1111;
    localparam logic [15:0] BR_MASK  = 16'b1000_0010_0110_0000;

    if (IMM_W < 1 || IMM_W > DATA_W) begin : g_bad_imm_w
        $error("decode_stage: IMM_W must be in 1..DATA_W");
    end

    logic               alive;
    logic               skid_full;
    logic [INSTR_W-1:0] out_word;
    logic [INSTR_W-1:0] skid_word;
    logic               accept;

    assign in_ready = alive && !skid_full && !halted;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alive        <= 1'b0;
            out_valid    <= 1'b0;
            skid_full    <= 1'b0;
            halted       <= 1'b0;
            out_word     <= '0;
            skid_word    <= '0;
            decode_count <= '0;
        end else begin
            alive <= 1'b1;
            if (flush) begin
                out_valid <= 1'b0;
                skid_full <= 1'b0;
                halted    <= 1'b0;
            end else begin
                if (accept && in_instr[INSTR_W-1 -: 4] == 4'hD)
                    halted <= 1'b1;
                if (!out_valid || out_ready) begin
                    out_valid <= skid_full || accept;
                    if (skid_full) begin
                        out_word  <= skid_word;
                        skid_full <= 1'b0;
                    end else if (accept) begin
                        out_word <= in_instr;
                    end
                end else if (accept) begin
                    skid_word <= in_instr;
                    skid_full <= 1'b1;
                end
                if (out_valid && out_ready && decode_count != '1)
                    decode_count <= decode_count + CNT_W'(1);
            end
        end
    end

    logic [3:0]       op;
    logic             no_regs;
    logic             imm_cls;
    logic [IMM_W-1:0] imm_raw;

    assign op      = out_word[INSTR_W-1 -: 4];
    assign no_regs = op == 4'h9 || op == 4'hD;
    assign imm_cls = IMM_MASK[op];
    assign imm_raw = out_word[IMM_W-1:0];

    // Payload is gated by out_valid so an empty or reset stage shows all zeros.
    assign out_opcode      = out_valid ? op : '0;
    assign out_rd          = (out_valid && !no_regs) ? out_word[INSTR_W-5 -: REG_AW] : '0;
    assign out_rs1         = (out_valid && !no_regs) ? out_word[INSTR_W-5-REG_AW -: REG_AW] : '0;
    assign out_rs2         = (out_valid && !no_regs && !imm_cls) ? out_word[INSTR_W-5-2*REG_AW -: REG_AW] : '0;
    assign out_is_imm      = out_valid && imm_cls;
    assign out_imm         = (!out_valid || no_regs) ? '0 :
                             (op == 4'hB || op == 4'hC) ? DATA_W'(imm_raw) : DATA_W'($signed(imm_raw));
    assign out_jump_target = out_valid ? out_word[INSTR_W-5:0] : '0;
    assign out_writes_rd   = out_valid && WR_MASK[op];
    assign out_is_branch   = out_valid && BR_MASK[op];
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table-driven decode checks through a scoreboard queue, plus
// hand-written stall, halt, flush, reset and counter-saturation sequences.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_instr = '0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_opcode;
    logic [2:0]  out_rd, out_rs1, out_rs2;
    logic        out_is_imm;
    logic [7:0]  out_imm;
    logic [11:0] out_jump_target;
    logic        out_writes_rd, out_is_branch, halted;
    logic [15:0] decode_count;

    logic        s_in_valid = 1'b0;
    logic [15:0] s_instr = 16'h1A5B;
    logic        s_in_ready, s_out_valid;
    logic        s_out_ready = 1'b0;
    logic [3:0]  s_opcode;
    logic [2:0]  s_rd, s_rs1, s_rs2;
    logic        s_is_imm;
    logic [7:0]  s_imm;
    logic [11:0] s_jt;
    logic        s_wr, s_br, s_halted;
    logic [3:0]  s_count;

    decode_stage u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_is_imm(out_is_imm), .out_imm(out_imm), .out_jump_target(out_jump_target),
        .out_writes_rd(out_writes_rd), .out_is_branch(out_is_branch), .halted(halted),
        .decode_count(decode_count)
    );

    decode_stage #(.CNT_W(4)) u_sat (
        .clk(clk), .reset_n(reset_n), .in_valid(s_in_valid), .in_instr(s_instr),
        .in_ready(s_in_ready), .flush(1'b0), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_opcode(s_opcode), .out_rd(s_rd), .out_rs1(s_rs1), .out_rs2(s_rs2),
        .out_is_imm(s_is_imm), .out_imm(s_imm), .out_jump_target(s_jt),
        .out_writes_rd(s_wr), .out_is_branch(s_br), .halted(s_halted),
        .decode_count(s_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [3:0]  op;
        logic [2:0]  rd, rs1, rs2;
        logic        is_imm;
        logic [7:0]  imm;
        logic [11:0] jt;
        logic        wr, br;
    } vec_t;

    vec_t tbl[10];
    vec_t hlt;
    vec_t q[$];
    int   errors = 0;
    int   checks = 0;
    logic [15:0] exp_count = '0;
    int   s_hs = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack_exp(input vec_t v);
        return 64'({v.op, v.rd, v.rs1, v.rs2, v.is_imm, v.imm, v.jt, v.wr, v.br});
    endfunction

    function automatic logic [63:0] pack_act();
        return 64'({out_opcode, out_rd, out_rs1, out_rs2, out_is_imm, out_imm,
                    out_jump_target, out_writes_rd, out_is_branch});
    endfunction

    // Scoreboard: each output handshake pops the oldest expected entry.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_count = '0;
        end else if (out_valid && out_ready && !flush) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 64'(out_opcode), 64'hFF);
            end else begin
                vec_t e;
                e = q.pop_front();
                chk($sformatf("decode_%h", e.instr), pack_act(), pack_exp(e));
            end
            if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
        end
        if (reset_n && s_out_valid && s_out_ready) s_hs++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t a, b, c;
        logic [15:0] cnt0;
        tbl[0] = '{16'h02BD, 4'h0, 3'd1, 3'd2, 3'd0, 1'b1, 8'hFD, 12'h2BD, 1'b1, 1'b0};
        tbl[1] = '{16'hC6FF, 4'hC, 3'd3, 3'd3, 3'd0, 1'b1, 8'h3F, 12'h6FF, 1'b1, 1'b0};
        tbl[2] = '{16'h9123, 4'h9, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 12'h123, 1'b0, 1'b1};
        tbl[3] = '{16'h1A5B, 4'h1, 3'd5, 3'd1, 3'd3, 1'b0, 8'h1B, 12'hA5B, 1'b1, 1'b0};
        tbl[4] = '{16'h5ABC, 4'h5, 3'd5, 3'd2, 3'd0, 1'b1, 8'hFC, 12'hABC, 1'b0, 1'b1};
        tbl[5] = '{16'hB7E0, 4'hB, 3'd3, 3'd7, 3'd0, 1'b1, 8'h20, 12'h7E0, 1'b1, 1'b0};
        tbl[6] = '{16'h4E38, 4'h4, 3'd7, 3'd0, 3'd7, 1'b0, 8'hF8, 12'hE38, 1'b1, 1'b0};
        tbl[7] = '{16'hF1C5, 4'hF, 3'd0, 3'd7, 3'd0, 1'b1, 8'h05, 12'h1C5, 1'b0, 1'b1};
        tbl[8] = '{16'hAFFF, 4'hA, 3'd7, 3'd7, 3'd0, 1'b1, 8'hFF, 12'hFFF, 1'b0, 1'b0};
        tbl[9] = '{16'h7249, 4'h7, 3'd1, 3'd1, 3'd1, 1'b0, 8'h09, 12'h249, 1'b1, 1'b0};
        hlt    = '{16'hD000, 4'hD, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 12'h000, 1'b0, 1'b0};

        // Reset state
        repeat (2) step();
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_halted", 64'(halted), 0);
        chk("rst_count", 64'(decode_count), 0);
        chk("rst_payload", pack_act(), 0);
        reset_n = 1'b1;
        step();
        chk("ready_after_release", 64'(in_ready), 1);

        // Streaming table with out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("stream_ready_%0d", i), 64'(in_ready), 1);
            in_valid = 1'b1;
            in_instr = tbl[i].instr;
            q.push_back(tbl[i]);
            step();
            if (i == 0) chk("first_latency", 64'(out_valid), 1);
        end
        in_valid = 1'b0;
        repeat (2) step();
        chk("table_drained", 64'(q.size()), 0);
        chk("table_count", 64'(decode_count), 64'(exp_count));

        // Back-pressure: A, B fill both entries, C waits at the input
        a = tbl[3]; b = tbl[4]; c = tbl[5];
        cnt0 = exp_count;
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = a.instr; q.push_back(a);
        step();
        chk("bp_ready_after_a", 64'(in_ready), 1);
        in_instr = b.instr; q.push_back(b);
        step();
        chk("bp_ready_skid_full", 64'(in_ready), 0);
        in_instr = c.instr; q.push_back(c);
        repeat (2) step();
        chk("bp_hold_a", pack_act(), pack_exp(a));
        chk("bp_hold_valid", 64'(out_valid), 1);
        out_ready = 1'b1;
        step();
        chk("bp_ready_reopens", 64'(in_ready), 1);
        step();
        in_valid = 1'b0;
        step();
        chk("bp_count_plus3", 64'(decode_count), 64'(cnt0 + 16'd3));
        chk("bp_drained", 64'(q.size()), 0);

        // HLT stops intake but is still delivered; flush reopens
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = hlt.instr; q.push_back(hlt);
        step();
        in_instr = tbl[0].instr;
        chk("hlt_halted", 64'(halted), 1);
        chk("hlt_in_ready", 64'(in_ready), 0);
        step();
        out_ready = 1'b1;
        repeat (3) step();
        chk("hlt_no_accept", 64'(out_valid), 0);
        chk("hlt_still_halted", 64'(halted), 1);
        chk("hlt_delivered", 64'(q.size()), 0);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_halted", 64'(halted), 0);
        chk("flush_valid", 64'(out_valid), 0);
        chk("flush_ready", 64'(in_ready), 1);

        // Flush with full skid and an offered word
        out_ready = 1'b0;
        cnt0 = exp_count;
        in_valid = 1'b1; in_instr = tbl[6].instr;
        step();
        in_instr = tbl[7].instr;
        step();
        chk("pre_flush_full", 64'(in_ready), 0);
        in_instr = tbl[8].instr; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_full_valid", 64'(out_valid), 0);
        chk("flush_full_ready", 64'(in_ready), 1);
        chk("flush_count_kept", 64'(decode_count), 64'(cnt0));
        step();
        chk("flush_input_dropped", 64'(out_valid), 0);
        in_valid = 1'b1; in_instr = tbl[9].instr; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_accept_dropped", 64'(out_valid), 0);
        step();
        chk("flush_accept_still_empty", 64'(out_valid), 0);

        // Asynchronous reset mid-stream
        in_valid = 1'b1; in_instr = tbl[0].instr;
        step();
        in_instr = tbl[1].instr;
        step();
        in_valid = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        chk("areset_valid", 64'(out_valid), 0);
        chk("areset_count", 64'(decode_count), 0);
        chk("areset_ready", 64'(in_ready), 0);
        chk("areset_payload", pack_act(), 0);
        repeat (2) step();
        reset_n = 1'b1;
        step();
        chk("areset_release_ready", 64'(in_ready), 1);
        chk("areset_entries_gone", 64'(out_valid), 0);

        // Saturation on the CNT_W=4 instance
        s_in_valid = 1'b1; s_out_ready = 1'b1;
        repeat (11) step();
        chk("sat_mid", 64'(s_count), 10);
        repeat (14) step();
        chk("sat_enough_hs", 64'(s_hs >= 16), 1);
        chk("sat_count", 64'(s_count), 64'hF);
        repeat (3) step();
        chk("sat_hold", 64'(s_count), 64'hF);
        s_in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter INSTR_W, default 16, instruction width.
REQ-002 SHALL have parameter REG_AW, default 3, register-index width.
REQ-003 SHALL have parameter DATA_W, default 8, datapath width for the extended immediate.
REQ-004 SHALL have parameter CNT_W, default 16, decoded-instruction counter width.
REQ-005 SHALL derive IMM_W = INSTR_W-4-2*REG_AW and JMP_W = INSTR_W-4.
REQ-006 SHALL require IMM_W >= 1 and IMM_W <= DATA_W.
REQ-007 SHALL have ports, each as name, direction, width, meaning:
- clk  in  1  sole clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch word present.
- in_instr  in  INSTR_W  fetched instruction.
- in_ready  out  1  stage accepts in_instr this cycle.
- flush  in  1  synchronous kill of all held entries.
- out_valid  out  1  decoded entry present.
- out_ready  in  1  downstream consumes the entry.
- out_opcode  out  4  instr[top:top-3].
- out_rd  out  REG_AW  destination register.
- out_rs1  out  REG_AW  first operand register.
- out_rs2  out  REG_AW  second operand register.
- out_is_imm  out  1  use immediate, not rs2.
- out_imm  out  DATA_W  extended immediate.
- out_jump_target  out  JMP_W  instr[JMP_W-1:0].
- out_writes_rd  out  1  result written to rd.
- out_is_branch  out  1  beq, bne, blt or jump.
- halted  out  1  HLT accepted, intake stopped.
- decode_count  out  CNT_W  number of completed output handshakes.

Function
REQ-008 SHALL use opcodes 0 addi, 1 add, 2 lw, 3 subi, 4 sub, 5 beq, 6 bne, 7 slt, 8 slti, 9 jump, A sw, B sra, C sll, D HLT, E nand, F blt.
REQ-009 SHALL take rd, rs1 and rs2 from the three REG_AW fields below the opcode, in that order from the top, and take the immediate from the low IMM_W bits.
REQ-010 SHALL force rs2 to 0 for immediate-class opcodes.
REQ-011 SHALL force rd, rs1 and rs2 to 0 for jump and HLT.
REQ-012 SHALL set is_imm = 1 for opcodes 0, 2, 3, 5, 6, 8, A, B, C, E, F, and 0 otherwise.
REQ-013 SHALL sign-extend the immediate to DATA_W, except for sra and sll, which zero-extend; out_imm SHALL be 0 for jump and HLT.
REQ-014 SHALL set writes_rd = 1 for opcodes 0, 1, 2, 3, 4, 7, 8, B, C, E, and 0 otherwise.
REQ-015 SHALL provide two-entry storage: an output register and a skid register.
REQ-016 SHALL accept an instruction only when in_valid && in_ready.
REQ-017 SHALL place an accepted word into the output register when it is empty or out_ready = 1 that cycle; otherwise it SHALL go to the skid register.
REQ-018 SHALL drive in_ready = !skid_full && !halted, from registers only (no combinational path from out_ready).
REQ-019 SHALL, when the output register is consumed while the skid is full, move the skid entry to the output register in the same edge.
REQ-020 SHALL deliver entries in strict acceptance order, with no loss and no duplication.
REQ-021 SHALL present an accepted instruction with out_valid = 1 one cycle after acceptance when the stage was empty.
REQ-022 SHALL hold out_valid and all payload outputs stable while out_valid && !out_ready.
REQ-023 SHALL set halted on the edge that accepts an HLT, and the HLT itself SHALL still propagate downstream.
REQ-024 SHALL keep halted set until flush or reset.
REQ-025 SHALL, on flush = 1, empty both entries and clear halted at the next edge; any accept in that cycle is discarded, flush takes priority, and decode_count is unaffected.
REQ-026 SHALL increment decode_count on each out_valid && out_ready when flush = 0, saturating at all-ones.

Reset
REQ-027 SHALL, while reset_n = 0, drive all outputs to 0 (including out_valid, halted, decode_count and all payload outputs) with both entries empty.
REQ-028 SHALL drive in_ready = 0 while reset_n = 0, and in_ready = 1 from the first edge after release.
REQ-029 SHALL, on reset assertion mid-operation, discard held entries immediately (asynchronously).

Verification
REQ-030 SHALL cover: 0x02BD accepted into empty stage -> next cycle out_valid=1, opcode=0, rd=1, rs1=2, rs2=0, is_imm=1, imm=8'hFD, writes_rd=1.
REQ-031 SHALL cover: 0xC6FF (sll) -> imm=8'h3F (zero-extended), rd=3, rs1=3; 0x9123 (jump) -> jump_target=12'h123, is_branch=1, writes_rd=0, rd=0.
REQ-032 SHALL cover: out_ready=0, accept A then B -> in_ready=0 next cycle, C held at input; raise out_ready -> outputs A, B, C in consecutive cycles, decode_count=3.
REQ-033 SHALL cover: accept 0xD000 followed by offered 0x02BD -> halted=1, in_ready=0, HLT delivered, 0x02BD not accepted; pulse flush -> halted=0, out_valid=0, in_ready=1.
REQ-034 SHALL cover: flush coinciding with in_valid and a full skid -> both entries empty next cycle and the input dropped; reset_n low mid-stream -> out_valid=0 and decode_count=0 immediately.
REQ-035 SHALL cover: decode_count preloaded near max via 2^CNT_W handshakes at CNT_W=4 -> count holds at 4'hF.
